// File: rtl/wash_sequencer_pkg.sv
// Shared types and default durations for the wash programme sequencer.
package wash_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FILL        = 3'd1,
        S_WASH        = 3'd2,
        S_DRAIN       = 3'd3,
        S_RFILL       = 3'd4,
        S_RINSE       = 3'd5,
        S_SPIN        = 3'd6,
        S_ABORT_DRAIN = 3'd7
    } state_t;

    localparam logic [1:0] MOTOR_OFF  = 2'd0;
    localparam logic [1:0] MOTOR_SLOW = 2'd1;
    localparam logic [1:0] MOTOR_FAST = 2'd2;

    localparam logic [7:0] FILL_T_DEF  = 8'd3;
    localparam logic [7:0] WASH_T_DEF  = 8'd5;
    localparam logic [7:0] DRAIN_T_DEF = 8'd2;
    localparam logic [7:0] RINSE_T_DEF = 8'd4;
    localparam logic [7:0] SPIN_T_DEF  = 8'd6;
    localparam logic [1:0] RINSES_DEF  = 2'd2;

endpackage

// File: rtl/wash_sequencer_timer.sv
// 8-bit countdown timer: irq is high for the one cycle the armed count sits at
// zero, after which the timer parks idle until the next load.
module wash_sequencer_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] set,
    input  logic       load,
    output logic       irq
);

    logic [7:0] count;
    logic       armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
            armed <= 1'b0;
        end else if (load) begin
            count <= set;
            armed <= 1'b1;
        end else if (armed) begin
            if (count == 8'd0) armed <= 1'b0;
            else               count <= count - 8'd1;
        end
    end

    assign irq = armed && (count == 8'd0);

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine programme sequencer: fill, wash, drain, N rinse cycles, spin,
// with abort-to-drain. Each timed state lasts its duration + 2 cycles.
module wash_sequencer
    import wash_sequencer_pkg::*;
#(
    parameter logic [7:0] FILL_T  = FILL_T_DEF,
    parameter logic [7:0] WASH_T  = WASH_T_DEF,
    parameter logic [7:0] DRAIN_T = DRAIN_T_DEF,
    parameter logic [7:0] RINSE_T = RINSE_T_DEF,
    parameter logic [7:0] SPIN_T  = SPIN_T_DEF,
    parameter logic [1:0] RINSES  = RINSES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       water_in,
    output logic       drain,
    output logic [1:0] motor,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase
);

    state_t     state, state_next;
    logic [1:0] rinses_done, rinses_next;
    logic [7:0] set, set_next;
    logic       load, load_next;
    logic       done_next;
    logic       irq;
    logic       expired;

    wash_sequencer_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .set  (set),
        .load (load),
        .irq  (irq)
    );

    // The timer still holds the previous state's count during a load cycle.
    assign expired = irq && !load;

    always_comb begin
        state_next  = state;
        rinses_next = rinses_done;
        done_next   = 1'b0;
        case (state)
            S_IDLE:        if (start)   state_next = S_FILL;
            S_FILL:        if (expired) state_next = S_WASH;
            S_WASH:        if (expired) state_next = S_DRAIN;
            S_DRAIN:       if (expired) state_next = (rinses_done < RINSES) ? S_RFILL : S_SPIN;
            S_RFILL:       if (expired) state_next = S_RINSE;
            S_RINSE: begin
                if (expired) begin
                    state_next  = S_DRAIN;
                    rinses_next = (rinses_done == 2'd3) ? 2'd3 : rinses_done + 2'd1;
                end
            end
            S_SPIN: begin
                if (expired) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            S_ABORT_DRAIN: if (expired) state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase

        if (abort && state != S_IDLE && state != S_ABORT_DRAIN) begin
            state_next  = S_ABORT_DRAIN;
            rinses_next = rinses_done;
            done_next   = 1'b0;
        end

        if (state_next == S_FILL && state != S_FILL) rinses_next = 2'd0;

        load_next = (state_next != state) && (state_next != S_IDLE);
        set_next  = 8'd0;
        if (load_next) begin
            case (state_next)
                S_FILL, S_RFILL:        set_next = FILL_T;
                S_WASH:                 set_next = WASH_T;
                S_DRAIN, S_ABORT_DRAIN: set_next = DRAIN_T;
                S_RINSE:                set_next = RINSE_T;
                S_SPIN:                 set_next = SPIN_T;
                default:                set_next = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rinses_done <= 2'd0;
            load        <= 1'b0;
            set         <= 8'd0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            rinses_done <= rinses_next;
            load        <= load_next;
            set         <= set_next;
            done        <= done_next;
        end
    end

    always_comb begin
        water_in = (state == S_FILL) || (state == S_RFILL);
        drain    = (state == S_DRAIN) || (state == S_SPIN) || (state == S_ABORT_DRAIN);
        motor    = MOTOR_OFF;
        if (state == S_WASH || state == S_RINSE) motor = MOTOR_SLOW;
        if (state == S_SPIN)                     motor = MOTOR_FAST;
    end

    assign busy  = (state != S_IDLE);
    assign phase = state;

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench: per-cycle expected output words are queued when a scenario
// is launched and popped one per clock against the live outputs.
module tb_wash_sequencer;
    import wash_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, abort, start1, abort1;
    logic       water_in, drain, busy, done;
    logic [1:0] motor;
    logic [2:0] phase;
    logic       water_in1, drain1, busy1, done1;
    logic [1:0] motor1;
    logic [2:0] phase1;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         sel = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    wash_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .water_in(water_in), .drain(drain), .motor(motor),
        .busy(busy), .done(done), .phase(phase)
    );

    wash_sequencer #(.FILL_T(8'd0), .RINSES(2'd1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .water_in(water_in1), .drain(drain1), .motor(motor1),
        .busy(busy1), .done(done1), .phase(phase1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    // Expected word {phase, water_in, drain, motor, busy, done} for a state.
    function automatic logic [8:0] enc(input state_t ph, input logic dn);
        logic       w, d, b;
        logic [1:0] m;
        w = (ph == S_FILL) || (ph == S_RFILL);
        d = (ph == S_DRAIN) || (ph == S_SPIN) || (ph == S_ABORT_DRAIN);
        m = (ph == S_WASH || ph == S_RINSE) ? 2'd1 : (ph == S_SPIN) ? 2'd2 : 2'd0;
        b = (ph != S_IDLE);
        return {ph, w, d, m, b, dn};
    endfunction

    task automatic push(input state_t ph, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(enc(ph, 1'b0));
    endtask

    task automatic push_prog(input int fill_cyc, input int rinses);
        push(S_FILL, fill_cyc);
        push(S_WASH, 7);
        push(S_DRAIN, 4);
        for (int r = 0; r < rinses; r++) begin
            push(S_RFILL, fill_cyc);
            push(S_RINSE, 6);
            push(S_DRAIN, 4);
        end
        push(S_SPIN, 8);
    endtask

    task automatic tick();
        logic [8:0] e, a;
        e = exp_q.pop_front();
        a = sel ? {phase1, water_in1, drain1, motor1, busy1, done1}
                : {phase, water_in, drain, motor, busy, done};
        chk(sel ? "outputs_r1" : "outputs", 32'(a), 32'(e));
        chk("no_water_and_drain", 32'(sel ? (water_in1 & drain1) : (water_in & drain)), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic full_run(input logic abort_at_start);
        int i;
        push(S_IDLE, 1);
        push_prog(5, 2);
        exp_q.push_back(enc(S_IDLE, 1'b1));
        push(S_IDLE, 2);
        i = 0;
        while (exp_q.size() > 0) begin
            start = (i == 0);
            abort = abort_at_start && (i == 0);
            tick();
            i++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int i;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        push(S_IDLE, 1);
        chk("load_after_reset", 32'(dut.load), 32'd0);
        chk("set_after_reset", 32'(dut.set), 32'd0);
        tick();

        // Default programme timing, done at cycle 55
        full_run(1'b0);

        // Abort in the third WASH cycle; aborts in ABORT_DRAIN and IDLE ignored
        push(S_IDLE, 1); push(S_FILL, 5); push(S_WASH, 3);
        push(S_ABORT_DRAIN, 4); push(S_IDLE, 2);
        i = 0;
        while (exp_q.size() > 0) begin
            start = (i == 0);
            abort = (i == 8) || (i == 10) || (i == 13);
            if (i == 9) begin
                chk("abort_load", 32'(dut.load), 32'd1);
                chk("abort_set", 32'(dut.set), 32'd2);
            end
            tick();
            i++;
        end
        abort = 1'b0;

        // Single rinse, zero fill time
        sel = 1;
        push(S_IDLE, 1);
        push_prog(2, 1);
        exp_q.push_back(enc(S_IDLE, 1'b1));
        push(S_IDLE, 1);
        i = 0;
        while (exp_q.size() > 0) begin
            start1 = (i == 0);
            tick();
            i++;
        end
        start1 = 1'b0;
        sel = 0;

        // Reset in the middle of RINSE, then a full programme entered with start+abort
        push(S_IDLE, 1); push(S_FILL, 5); push(S_WASH, 7); push(S_DRAIN, 4);
        push(S_RFILL, 5); push(S_RINSE, 3); push(S_IDLE, 2);
        i = 0;
        while (exp_q.size() > 0) begin
            start = (i == 0);
            rst   = (i == 24);
            if (i == 25) begin
                chk("load_after_midreset", 32'(dut.load), 32'd0);
                chk("rinses_after_midreset", 32'(dut.rinses_done), 32'd0);
            end
            tick();
            i++;
        end
        rst = 1'b0;
        full_run(1'b1);

        // start held high: back-to-back programmes; abort on the SPIN expiry cycle
        push(S_IDLE, 1);
        push_prog(5, 2);
        exp_q.push_back(enc(S_IDLE, 1'b1));
        push_prog(5, 2);
        push(S_ABORT_DRAIN, 4);
        push(S_IDLE, 2);
        i = 0;
        while (exp_q.size() > 0) begin
            start = (i <= 100);
            abort = (i == 109);
            tick();
            i++;
        end
        start = 1'b0;
        abort = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
